// File: rtl/tone_period_meter_pkg.sv
// -----------------------------------------------------------------------------
// tone_period_meter_pkg
// Shared definitions for the tone period meter: measurement FSM states and
// the default counter width.
// -----------------------------------------------------------------------------
package tone_period_meter_pkg;

  localparam int CNT_W_DEFAULT = 16;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_FIRST = 2'd1,
    MEASURE    = 2'd2,
    NOSIG      = 2'd3
  } state_e;

endpackage

// File: rtl/tone_period_meter_sig_edge_sync.sv
// -----------------------------------------------------------------------------
// tone_period_meter_sig_edge_sync
// Two-flop synchronizer for an asynchronous level, followed by a delay flop
// used to derive single-cycle rise/fall strobes in the i_clk domain.
//
// Ports:
//   i_clk   system clock (rising edge)
//   i_rst   asynchronous active-high reset, all flops to 0
//   i_sig   asynchronous input level
//   o_rise  high for one cycle after a synchronized 0->1 transition
//   o_fall  high for one cycle after a synchronized 1->0 transition
// -----------------------------------------------------------------------------
module tone_period_meter_sig_edge_sync (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_sig,
  output logic o_rise,
  output logic o_fall
);

  logic r_s1;
  logic r_s2;
  logic r_s3;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= i_sig;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  assign o_rise = r_s2 & ~r_s3;
  assign o_fall = ~r_s2 & r_s3;

endmodule

// File: rtl/tone_period_meter.sv
// -----------------------------------------------------------------------------
// tone_period_meter
// Measures period and high time of an asynchronous square wave in i_clk
// cycles. Each completed period is reported with a one-cycle valid pulse;
// absence of a rising edge for MAX cycles raises a timeout level.
//
// Ports:
//   i_clk            system clock (rising edge)
//   i_rst            asynchronous active-high reset
//   i_en             measurement enable; low returns to IDLE
//   i_sig_in         asynchronous tone under test
//   o_period         cycles between successive detected rising edges
//   o_high_time      cycles from rising edge to following falling edge
//   o_period_valid   one-cycle pulse when o_period/o_high_time update
//   o_timeout        no rising edge within MAX cycles
// -----------------------------------------------------------------------------
module tone_period_meter
  import tone_period_meter_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic             i_sig_in,
  output logic [CNT_W-1:0] o_period,
  output logic [CNT_W-1:0] o_high_time,
  output logic             o_period_valid,
  output logic             o_timeout
);

  // Last count value before the counter would have to report more than MAX.
  localparam logic [CNT_W-1:0] C_MAX_M1 = {{(CNT_W-1){1'b1}}, 1'b0};

  logic w_rise;
  logic w_fall;

  state_e           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_hcap;
  logic [CNT_W-1:0] r_period;
  logic [CNT_W-1:0] r_high;
  logic             r_pv;
  logic             r_to;

  state_e           w_state_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [CNT_W-1:0] w_hcap_nxt;
  logic [CNT_W-1:0] w_period_nxt;
  logic [CNT_W-1:0] w_high_nxt;
  logic             w_pv_nxt;
  logic             w_to_nxt;
  logic [CNT_W-1:0] w_cnt_inc;

  tone_period_meter_sig_edge_sync u_sig_edge_sync (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_sig  (i_sig_in),
    .o_rise (w_rise),
    .o_fall (w_fall)
  );

  // cnt holds (cycles since the rise) - 1, so cnt+1 is the elapsed count.
  assign w_cnt_inc = r_cnt + CNT_W'(1);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_hcap   <= '0;
      r_period <= '0;
      r_high   <= '0;
      r_pv     <= 1'b0;
      r_to     <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_hcap   <= w_hcap_nxt;
      r_period <= w_period_nxt;
      r_high   <= w_high_nxt;
      r_pv     <= w_pv_nxt;
      r_to     <= w_to_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_hcap_nxt   = r_hcap;
    w_period_nxt = r_period;
    w_high_nxt   = r_high;
    w_pv_nxt     = 1'b0;
    w_to_nxt     = r_to;

    if (!i_en) begin
      // Enable dominates any edge seen on the same cycle.
      w_state_nxt = IDLE;
      w_cnt_nxt   = '0;
      w_to_nxt    = 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          w_cnt_nxt   = '0;
          w_to_nxt    = 1'b0;
          w_state_nxt = WAIT_FIRST;
        end
        WAIT_FIRST: begin
          if (w_rise) begin
            w_cnt_nxt   = '0;
            w_state_nxt = MEASURE;
          end
        end
        MEASURE: begin
          if (w_fall) begin
            w_hcap_nxt = w_cnt_inc;
          end
          // A rise coinciding with the terminal count reports MAX, no timeout.
          if (w_rise) begin
            w_period_nxt = w_cnt_inc;
            w_high_nxt   = r_hcap;
            w_pv_nxt     = 1'b1;
            w_cnt_nxt    = '0;
          end else if (r_cnt == C_MAX_M1) begin
            w_state_nxt = NOSIG;
            w_to_nxt    = 1'b1;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = w_cnt_inc;
          end
        end
        NOSIG: begin
          // First edge after loss of signal only restarts timing.
          if (w_rise) begin
            w_to_nxt    = 1'b0;
            w_cnt_nxt   = '0;
            w_state_nxt = MEASURE;
          end
        end
        default: begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  assign o_period       = r_period;
  assign o_high_time    = r_high;
  assign o_period_valid = r_pv;
  assign o_timeout      = r_to;

endmodule

// File: tb/tb_tone_period_meter.sv
// -----------------------------------------------------------------------------
// tb_tone_period_meter
// Directed and randomized tone patterns against an elapsed-time reference
// model. The model records the input level seen at every clock edge, finds
// synchronized edges two edges later, and derives period/high time as the
// difference between edge timestamps.
// -----------------------------------------------------------------------------
module tb_tone_period_meter;

  localparam int W   = 8;
  localparam int MAX = (1 << W) - 1;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         en = 1'b0;
  logic         sig_in = 1'b0;
  logic [W-1:0] period;
  logic [W-1:0] high_time;
  logic         period_valid;
  logic         timeout;

  tone_period_meter #(.CNT_W(W)) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_en           (en),
    .i_sig_in       (sig_in),
    .o_period       (period),
    .o_high_time    (high_time),
    .o_period_valid (period_valid),
    .o_timeout      (timeout)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state
  typedef enum {M_OFF, M_ARMED, M_TIMING, M_LOST} mode_e;
  mode_e        mode = M_OFF;
  bit           lvl[0:65535];
  int           m = 3;          // index of the next clock edge
  int           t_rise = 0;     // edge at which the last rise was acted on
  logic [W-1:0] hval = '0;
  logic [W-1:0] e_period = '0;
  logic [W-1:0] e_high = '0;
  logic         e_pv = 1'b0;
  logic         e_to = 1'b0;
  int           n_pv = 0;
  int           n_to = 0;

  task automatic model_edge();
    bit rise, fall;
    lvl[m] = rst ? 1'b0 : sig_in;
    rise = lvl[m-2] && !lvl[m-3];
    fall = !lvl[m-2] && lvl[m-3];
    e_pv = 1'b0;
    if (rst) begin
      mode = M_OFF; e_period = '0; e_high = '0; e_to = 1'b0; hval = '0;
    end else if (!en) begin
      mode = M_OFF; e_to = 1'b0;
    end else begin
      case (mode)
        M_OFF:   mode = M_ARMED;
        M_ARMED: if (rise) begin mode = M_TIMING; t_rise = m; end
        M_TIMING: begin
          if (fall) hval = W'(m - t_rise);
          if (rise) begin
            e_period = W'(m - t_rise);
            e_high   = hval;
            e_pv     = 1'b1;
            t_rise   = m;
          end else if (m - t_rise == MAX) begin
            mode = M_LOST; e_to = 1'b1;
          end
        end
        M_LOST: if (rise) begin mode = M_TIMING; e_to = 1'b0; t_rise = m; end
        default: mode = M_OFF;
      endcase
    end
    m++;
  endtask

  task automatic check_all();
    vectors++;
    assert (period === e_period) else begin
      miscompares++; $error("FAIL period obs=%0d exp=%0d edge=%0d", period, e_period, m);
    end
    vectors++;
    assert (high_time === e_high) else begin
      miscompares++; $error("FAIL high_time obs=%0d exp=%0d edge=%0d", high_time, e_high, m);
    end
    vectors++;
    assert (period_valid === e_pv) else begin
      miscompares++; $error("FAIL period_valid obs=%b exp=%b edge=%0d", period_valid, e_pv, m);
    end
    vectors++;
    assert (timeout === e_to) else begin
      miscompares++; $error("FAIL timeout obs=%b exp=%b edge=%0d", timeout, e_to, m);
    end
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++; $error("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
    end
  endtask

  task automatic step(input bit s);
    @(negedge clk);
    sig_in = s;
    @(posedge clk);
    model_edge();
    #1;
    check_all();
    if (period_valid === 1'b1) n_pv++;
    if (timeout === 1'b1) n_to++;
  endtask

  task automatic wave(input int hi, input int lo, input int n);
    for (int i = 0; i < n; i++) begin
      repeat (hi) step(1'b1);
      repeat (lo) step(1'b0);
    end
  endtask

  task automatic pulse_rst();
    @(negedge clk);
    rst = 1'b1;
    lvl[m-1] = 1'b0; lvl[m-2] = 1'b0; lvl[m-3] = 1'b0;
    mode = M_OFF; e_period = '0; e_high = '0; e_pv = 1'b0; e_to = 1'b0; hval = '0;
    #1;
    check_all();
    step(1'b0);
    rst = 1'b0;
  endtask

  initial begin
    int hi, lo;
    // Reset values
    #1;
    chk("rst_period", int'(period), 0);
    chk("rst_high", int'(high_time), 0);
    chk("rst_valid", int'(period_valid), 0);
    chk("rst_timeout", int'(timeout), 0);
    repeat (2) step(1'b0);
    rst = 1'b0;
    repeat (3) step(1'b0);

    // 50/50 divider: first valid after second rise, then 100/50
    en = 1'b1; n_pv = 0;
    wave(50, 50, 6);
    chk("p1_valids", n_pv, 5);
    chk("p1_period", int'(period), 100);
    chk("p1_high", int'(high_time), 50);

    // 30 high / 70 low
    n_pv = 0; n_to = 0;
    wave(30, 70, 5);
    chk("p2_valids", n_pv, 5);
    chk("p2_period", int'(period), 100);
    chk("p2_high", int'(high_time), 30);
    chk("p2_timeouts", n_to, 0);

    // Loss of signal after one rise
    n_pv = 0; n_to = 0;
    repeat (5) step(1'b1);
    repeat (300) step(1'b0);
    chk("p3_timeout", int'(timeout), 1);
    chk("p3_timeout_cycles", n_to, 48);
    chk("p3_period_hold", int'(period), 100);
    chk("p3_valids", n_pv, 1);
    n_pv = 0;
    wave(20, 80, 1);
    chk("p3_restart_valids", n_pv, 0);
    chk("p3_timeout_clr", int'(timeout), 0);
    wave(20, 80, 1);
    chk("p3_first_valid", n_pv, 1);
    chk("p3_high", int'(high_time), 20);

    // Rises 255 apart: report MAX, never time out
    n_pv = 0; n_to = 0;
    wave(10, 245, 4);
    repeat (10) step(1'b1);
    chk("p4_timeouts", n_to, 0);
    chk("p4_period_max", int'(period), MAX);
    chk("p4_valids", n_pv, 5);

    // 256+ spacing: timeout asserts
    repeat (250) step(1'b0);
    chk("p5_timeout", int'(timeout), 1);
    chk("p5_period_hold", int'(period), MAX);

    // Recover, then drop enable mid-period
    n_pv = 0;
    wave(40, 60, 3);
    chk("p6_valids", n_pv, 2);
    repeat (20) step(1'b1);
    en = 1'b0;
    repeat (30) step(1'b0);
    chk("p6_period_hold", int'(period), 100);
    en = 1'b1; n_pv = 0;
    wave(40, 60, 1);
    chk("p6_no_valid", n_pv, 0);
    chk("p6_period_hold2", int'(period), 100);
    wave(40, 60, 1);
    chk("p6_valid_after_two", n_pv, 1);

    // Enable falling on the same cycle the rise is acted on
    repeat (10) step(1'b0);
    n_pv = 0;
    step(1'b1); step(1'b1);
    en = 1'b0;
    step(1'b1); step(1'b1);
    chk("p6_en_wins", n_pv, 0);
    en = 1'b1;
    repeat (50) step(1'b0);
    wave(30, 70, 2);
    repeat (10) step(1'b1);

    // Reset mid-measurement
    pulse_rst();
    chk("p7_period_zero", int'(period), 0);
    n_pv = 0;
    repeat (50) step(1'b0);
    wave(30, 70, 3);
    chk("p7_valids", n_pv, 2);
    chk("p7_period", int'(period), 100);
    chk("p7_high", int'(high_time), 30);

    // Randomized tones, occasional long gaps and enable drops
    for (int k = 0; k < 30; k++) begin
      hi = int'($urandom_range(2, 120));
      lo = int'($urandom_range(2, 120));
      if ($urandom_range(0, 7) == 0) lo = lo + 200;
      wave(hi, lo, 1);
      if ($urandom_range(0, 9) == 0) begin
        en = 1'b0;
        repeat (int'($urandom_range(1, 20))) step(1'($urandom_range(0, 1)));
        en = 1'b1;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
